// File: rtl/sprite_motion_ctrl.sv
// Sprite position generator: decodes PS/2 arrow make/break codes, merges push-buttons,
// and steps/clamps the sprite top-left corner once per frame on the synchronised screenEnd edge.

module sprite_axis_step #(
  parameter int PW   = 10,
  parameter int MAXV = 590,
  parameter int STEP = 1
) (
  input  logic [PW-1:0] pos,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] nxt
);
  localparam logic [PW:0] STEP_W = (PW+1)'(STEP);
  localparam logic [PW:0] MAX_W  = (PW+1)'(MAXV);

  logic [PW:0] wide;
  logic [PW:0] sum;

  // One extra bit of headroom so the clamp sees the carry instead of a wrapped value.
  always_comb begin
    wide = {1'b0, pos};
    sum  = wide + STEP_W;
    nxt  = pos;
    if (inc && !dec)
      nxt = (sum > MAX_W) ? MAX_W[PW-1:0] : sum[PW-1:0];
    else if (dec && !inc)
      nxt = (wide < STEP_W) ? '0 : pos - STEP_W[PW-1:0];
  end
endmodule

module sprite_motion_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int SPRITE_SIZE = 50,
  parameter int STEP        = 1,
  parameter int X_INIT      = 295,
  parameter int Y_INIT      = 215
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       screen_end,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [7:0] rx_data,
  input  logic       read_data,
  output logic [9:0] xpos,
  output logic [8:0] ypos,
  output logic [3:0] dir_held,
  output logic [7:0] key_code,
  output logic       key_pulse,
  output logic       frame_tick
);
  localparam int X_MAX = SCREEN_W - SPRITE_SIZE;
  localparam int Y_MAX = SCREEN_H - SPRITE_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} dec_state_e;

  dec_state_e state_q, state_d;
  logic [3:0] btn_s1_q, btn_s2_q;
  logic       se_s1_q, se_s2_q, se_s3_q;
  logic [3:0] held_q, held_d;
  logic [7:0] code_q, code_d;
  logic       pulse_q, pulse_d;
  logic       tick_q, tick_d;
  logic [9:0] x_q, x_d, x_nxt;
  logic [8:0] y_q, y_d, y_nxt;
  logic [3:0] arrow_bit;

  // Held bits use the same {up,down,left,right} order as dir_held.
  always_comb begin
    arrow_bit = 4'b0000;
    case (rx_data)
      8'h75:   arrow_bit = 4'b1000;
      8'h72:   arrow_bit = 4'b0100;
      8'h6B:   arrow_bit = 4'b0010;
      8'h74:   arrow_bit = 4'b0001;
      default: arrow_bit = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    code_d  = code_q;
    pulse_d = 1'b0;
    if (read_data) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == 8'hE0)      state_d = S_EXT;
          else if (rx_data == 8'hF0) state_d = S_BRK;
          else begin
            code_d  = rx_data;
            pulse_d = 1'b1;
          end
        end
        S_EXT: begin
          if (rx_data == 8'hE0)      state_d = S_EXT;
          else if (rx_data == 8'hF0) state_d = S_EXT_BRK;
          else begin
            code_d  = rx_data;
            pulse_d = 1'b1;
            held_d  = held_q | arrow_bit;
            state_d = S_IDLE;
          end
        end
        S_BRK:     state_d = S_IDLE;
        S_EXT_BRK: begin
          held_d  = held_q & ~arrow_bit;
          state_d = S_IDLE;
        end
        default:   state_d = S_IDLE;
      endcase
    end
  end

  assign dir_held = btn_s2_q | held_q;

  sprite_axis_step #(.PW(10), .MAXV(X_MAX), .STEP(STEP)) u_x (
    .pos(x_q), .inc(dir_held[0]), .dec(dir_held[1]), .nxt(x_nxt)
  );
  sprite_axis_step #(.PW(9), .MAXV(Y_MAX), .STEP(STEP)) u_y (
    .pos(y_q), .inc(dir_held[2]), .dec(dir_held[3]), .nxt(y_nxt)
  );

  // Position moves on the same edge that raises frame_tick, using pre-edge dir_held.
  always_comb begin
    tick_d = se_s2_q & ~se_s3_q;
    x_d    = tick_d ? x_nxt : x_q;
    y_d    = tick_d ? y_nxt : y_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      se_s1_q  <= 1'b0;
      se_s2_q  <= 1'b0;
      se_s3_q  <= 1'b0;
      state_q  <= S_IDLE;
      held_q   <= '0;
      code_q   <= 8'h00;
      pulse_q  <= 1'b0;
      tick_q   <= 1'b0;
      x_q      <= 10'(X_INIT);
      y_q      <= 9'(Y_INIT);
    end else begin
      btn_s1_q <= {btn_up, btn_down, btn_left, btn_right};
      btn_s2_q <= btn_s1_q;
      se_s1_q  <= screen_end;
      se_s2_q  <= se_s1_q;
      se_s3_q  <= se_s2_q;
      state_q  <= state_d;
      held_q   <= held_d;
      code_q   <= code_d;
      pulse_q  <= pulse_d;
      tick_q   <= tick_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign xpos       = x_q;
  assign ypos       = y_q;
  assign key_code   = code_q;
  assign key_pulse  = pulse_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed plus randomized bench for sprite_motion_ctrl against a byte-level keyboard
// model and integer position arithmetic.

module tb_sprite_motion_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       screen_end = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       read_data = 1'b0;
  logic [9:0] xpos;
  logic [8:0] ypos;
  logic [3:0] dir_held;
  logic [7:0] key_code;
  logic       key_pulse;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;

  // reference state
  int         m_x, m_y;
  logic [3:0] m_held, m_btn;
  logic [7:0] m_code;
  bit         m_ext, m_brk;

  sprite_motion_ctrl dut (
    .clk(clk), .reset(reset), .screen_end(screen_end),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .rx_data(rx_data), .read_data(read_data),
    .xpos(xpos), .ypos(ypos), .dir_held(dir_held),
    .key_code(key_code), .key_pulse(key_pulse), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] arrow_mask(input logic [7:0] b);
    if (b == 8'h75) return 4'b1000;
    if (b == 8'h72) return 4'b0100;
    if (b == 8'h6B) return 4'b0010;
    if (b == 8'h74) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    #1;
    chk("rst_x", 32'(xpos), 32'd295);
    chk("rst_y", 32'(ypos), 32'd215);
    chk("rst_code", 32'(key_code), 32'h00);
    chk("rst_pulse", 32'(key_pulse), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_dir", 32'(dir_held), 32'd0);
    @(negedge clk) reset = 1'b0;
    m_x = 295; m_y = 215; m_held = '0; m_code = 8'h00; m_ext = 0; m_brk = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_btn(input logic [3:0] v);
    @(negedge clk) {btn_up, btn_down, btn_left, btn_right} = v;
    repeat (3) @(negedge clk);
    m_btn = v;
    chk("btn_dir", 32'(dir_held), 32'(m_btn | m_held));
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit exp_pulse;
    exp_pulse = 0;
    if (m_brk) begin
      if (m_ext) m_held = m_held & ~arrow_mask(b);
      m_brk = 0; m_ext = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      m_code = b; exp_pulse = 1;
      if (m_ext) m_held = m_held | arrow_mask(b);
      m_ext = 0;
    end
    @(negedge clk) begin rx_data = b; read_data = 1'b1; end
    @(negedge clk) read_data = 1'b0;
    chk("kpulse", 32'(key_pulse), 32'(exp_pulse));
    chk("kcode", 32'(key_code), 32'(m_code));
    chk("kdir", 32'(dir_held), 32'(m_btn | m_held));
    @(negedge clk);
    chk("kpulse_end", 32'(key_pulse), 32'd0);
  endtask

  task automatic do_frame();
    logic [3:0] d;
    int lat;
    d = m_btn | m_held;
    if (d[0] && !d[1]) m_x = (m_x + 1 > 590) ? 590 : m_x + 1;
    else if (d[1] && !d[0]) m_x = (m_x < 1) ? 0 : m_x - 1;
    if (d[2] && !d[3]) m_y = (m_y + 1 > 430) ? 430 : m_y + 1;
    else if (d[3] && !d[2]) m_y = (m_y < 1) ? 0 : m_y - 1;
    @(negedge clk) screen_end = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (frame_tick) begin lat = i; break; end
    end
    chk("tick_lat", 32'(lat), 32'd3);
    chk("fx", 32'(xpos), 32'(m_x));
    chk("fy", 32'(ypos), 32'(m_y));
    chk("f_nopulse", 32'(key_pulse), 32'd0);
    @(negedge clk);
    chk("tick_1clk", 32'(frame_tick), 32'd0);
    screen_end = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] pick [8];
    logic [7:0] b;
    m_btn = '0;
    pick[0] = 8'hE0; pick[1] = 8'hF0; pick[2] = 8'h75; pick[3] = 8'h72;
    pick[4] = 8'h6B; pick[5] = 8'h74; pick[6] = 8'h1C; pick[7] = 8'h00;

    // reset and idle frames
    do_reset();
    repeat (3) do_frame();
    chk("idle_x", 32'(xpos), 32'd295);

    // extended right arrow make, then release
    send_byte(8'hE0); send_byte(8'h74);
    chk("right_dir", 32'(dir_held), 32'b0001);
    repeat (5) do_frame();
    chk("right_x", 32'(xpos), 32'd300);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    chk("rel_dir", 32'(dir_held), 32'd0);
    repeat (2) do_frame();
    chk("rel_x", 32'(xpos), 32'd300);

    // left button down to the zero boundary
    set_btn(4'b0010);
    while (m_x > 2) do_frame();
    chk("at2_x", 32'(xpos), 32'd2);
    repeat (5) do_frame();
    chk("floor_x", 32'(xpos), 32'd0);

    // down button saturates at bottom
    set_btn(4'b0000);
    do_reset();
    set_btn(4'b0100);
    repeat (300) do_frame();
    chk("floor_y", 32'(ypos), 32'd430);

    // opposing buttons, plain key make/break
    set_btn(4'b0011);
    repeat (2) do_frame();
    send_byte(8'h1C);
    chk("a_code", 32'(key_code), 32'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    chk("a_keep", 32'(key_code), 32'h1C);

    // reset mid-sequence
    set_btn(4'b0000);
    send_byte(8'hE0); send_byte(8'h75);
    do_reset();
    send_byte(8'hE0);
    do_reset();
    send_byte(8'h72);
    chk("mid_dir", 32'(dir_held), 32'd0);
    chk("mid_code", 32'(key_code), 32'h72);
    chk("mid_x", 32'(xpos), 32'd295);
    chk("mid_y", 32'(ypos), 32'd215);

    // randomized mix of bytes, buttons and frames
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       set_btn(4'($urandom_range(0, 15)));
        1, 2, 3: do_frame();
        default: begin
          b = pick[$urandom_range(0, 7)];
          if (b == 8'h00) b = 8'($urandom_range(0, 255));
          send_byte(b);
        end
      endcase
    end
    do_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
